// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_pkg
//  Description : Shared constants and state encoding for the binary16
//                operand alignment stage (fp16_align_unit / fp16_unpack).
//                  EXP_W       - exponent field width
//                  MAN_W       - stored fraction width
//                  ALIGN_W     - aligned significand width (hidden + frac + GRS)
//                  GRS_W       - guard/round/sticky bit count
//                  CNT_W       - shift counter width
//                  EXP_MAX     - all-ones exponent (Inf/NaN)
//                  SHIFT_CLAMP - largest useful alignment shift
//  Revision    : 1.0 - initial release
// ============================================================================
package fp16_pkg;

    localparam int EXP_W       = 5;
    localparam int MAN_W       = 10;
    localparam int ALIGN_W     = 14;
    localparam int GRS_W       = 3;
    localparam int CNT_W       = 4;
    localparam int EXP_MAX     = 31;
    localparam int SHIFT_CLAMP = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp16_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_unpack
//  Description : Combinational binary16 field split. Inserts the hidden bit,
//                produces the effective exponent and flags Inf/NaN.
//                Build macro FP16_SUBNORMAL_EN:
//                  defined   - exponent field 0 gives hidden bit 0 and
//                              effective exponent 1 (exact subnormals)
//                  undefined - exponent field 0 flushes to zero
//                              (significand 0, effective exponent 0)
//  Ports       : i_op      - packed binary16 operand
//                o_sign    - sign bit (kept even when flushed)
//                o_exp     - effective exponent
//                o_sig     - significand with hidden bit, MAN_W+1 bits
//                o_special - exponent field is all ones
//  Revision    : 1.0 - initial release
// ============================================================================
module fp16_unpack #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic [EXP_W+MAN_W:0] i_op,
    output logic                 o_sign,
    output logic [EXP_W-1:0]     o_exp,
    output logic [MAN_W:0]       o_sig,
    output logic                 o_special
);
    import fp16_pkg::*;

    logic [EXP_W-1:0] w_exp_field;
    logic [MAN_W-1:0] w_frac;

    assign o_sign      = i_op[EXP_W+MAN_W];
    assign w_exp_field = i_op[EXP_W+MAN_W-1:MAN_W];
    assign w_frac      = i_op[MAN_W-1:0];
    assign o_special   = (w_exp_field == EXP_W'(EXP_MAX));

    always_comb begin
        o_exp = w_exp_field;
        o_sig = {1'b1, w_frac};
        if (w_exp_field == '0) begin
`ifdef FP16_SUBNORMAL_EN
            // Subnormals share the scale of exponent 1 without the hidden bit.
            o_exp = EXP_W'(1);
            o_sig = {1'b0, w_frac};
`else
            o_exp = '0;
            o_sig = '0;
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_align_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_align_unit
//  Description : Multi-cycle operand alignment for the binary16 adder.
//                Orders two operands by exponent and shifts the smaller
//                significand right one bit per cycle, accumulating G/R/S.
//                Optional build macro FP16_SUBNORMAL_EN (see fp16_unpack).
//  Ports       : Clk, Rst (async, active high)
//                A, B, In_valid, In_ready         - operand handshake
//                Out_valid, Out_ready             - result handshake
//                Exp_out, Mant_big, Mant_small,
//                Sign_big, Eff_sub, Special       - aligned result
//  Revision    : 1.0 - initial release
// ============================================================================
module fp16_align_unit #(
    parameter int EXP_W   = 5,
    parameter int MAN_W   = 10,
    parameter int ALIGN_W = 14
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    input  logic                 In_valid,
    output logic                 In_ready,
    output logic                 Out_valid,
    input  logic                 Out_ready,
    output logic [EXP_W-1:0]     Exp_out,
    output logic [ALIGN_W-1:0]   Mant_big,
    output logic [ALIGN_W-1:0]   Mant_small,
    output logic                 Sign_big,
    output logic                 Eff_sub,
    output logic                 Special
);
    import fp16_pkg::*;

    // ------------------------------------------------------------------
    // Unpack both operands
    // ------------------------------------------------------------------
    logic             w_sign_a, w_sign_b;
    logic [EXP_W-1:0] w_exp_a, w_exp_b;
    logic [MAN_W:0]   w_sig_a, w_sig_b;
    logic             w_spec_a, w_spec_b;

    fp16_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .i_op      (A),
        .o_sign    (w_sign_a),
        .o_exp     (w_exp_a),
        .o_sig     (w_sig_a),
        .o_special (w_spec_a)
    );

    fp16_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .i_op      (B),
        .o_sign    (w_sign_b),
        .o_exp     (w_exp_b),
        .o_sig     (w_sig_b),
        .o_special (w_spec_b)
    );

    // ------------------------------------------------------------------
    // Ordering: ties go to A; no significand compare is made here.
    // ------------------------------------------------------------------
    logic             w_a_big;
    logic [EXP_W-1:0] w_exp_big, w_exp_small, w_diff;
    logic [MAN_W:0]   w_sig_big, w_sig_small;
    logic             w_sign_big;
    logic [CNT_W-1:0] w_shift_amt;
    logic             w_special;
    logic             w_accept;

    assign w_a_big     = (w_exp_a >= w_exp_b);
    assign w_exp_big   = w_a_big ? w_exp_a  : w_exp_b;
    assign w_exp_small = w_a_big ? w_exp_b  : w_exp_a;
    assign w_sig_big   = w_a_big ? w_sig_a  : w_sig_b;
    assign w_sig_small = w_a_big ? w_sig_b  : w_sig_a;
    assign w_sign_big  = w_a_big ? w_sign_a : w_sign_b;
    assign w_diff      = w_exp_big - w_exp_small;
    assign w_special   = w_spec_a | w_spec_b;

    // Beyond SHIFT_CLAMP every significand bit already sits in sticky.
    assign w_shift_amt = (w_diff > EXP_W'(SHIFT_CLAMP)) ? CNT_W'(SHIFT_CLAMP)
                                                        : w_diff[CNT_W-1:0];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state_q,      w_state_d;
    logic [CNT_W-1:0]   r_cnt_q,        w_cnt_d;
    logic [EXP_W-1:0]   r_exp_q,        w_exp_d;
    logic [ALIGN_W-1:0] r_mant_big_q,   w_mant_big_d;
    logic [ALIGN_W-1:0] r_mant_small_q, w_mant_small_d;
    logic               r_sign_big_q,   w_sign_big_d;
    logic               r_eff_sub_q,    w_eff_sub_d;
    logic               r_special_q,    w_special_d;

    assign In_ready = (r_state_q == IDLE) && !Rst;
    assign w_accept = In_valid && In_ready;

    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_exp_d        = r_exp_q;
        w_mant_big_d   = r_mant_big_q;
        w_mant_small_d = r_mant_small_q;
        w_sign_big_d   = r_sign_big_q;
        w_eff_sub_d    = r_eff_sub_q;
        w_special_d    = r_special_q;

        case (r_state_q)
            IDLE: begin
                if (w_accept) begin
                    w_exp_d        = w_exp_big;
                    w_mant_big_d   = {w_sig_big,   {GRS_W{1'b0}}};
                    w_mant_small_d = {w_sig_small, {GRS_W{1'b0}}};
                    w_sign_big_d   = w_sign_big;
                    w_eff_sub_d    = w_sign_a ^ w_sign_b;
                    w_special_d    = w_special;
                    w_cnt_d        = w_shift_amt;
                    if (w_special || (w_shift_amt == '0)) begin
                        w_state_d = DONE;
                    end else begin
                        w_state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                // Bits leaving position 1 fold into the sticky bit at 0.
                w_mant_small_d = {1'b0, r_mant_small_q[ALIGN_W-1:2],
                                  r_mant_small_q[1] | r_mant_small_q[0]};
                w_cnt_d        = r_cnt_q - CNT_W'(1);
                if (r_cnt_q <= CNT_W'(1)) begin
                    w_state_d = DONE;
                end
            end

            DONE: begin
                if (Out_ready) begin
                    w_state_d = IDLE;
                end
            end

            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state_q      <= IDLE;
            r_cnt_q        <= '0;
            r_exp_q        <= '0;
            r_mant_big_q   <= '0;
            r_mant_small_q <= '0;
            r_sign_big_q   <= 1'b0;
            r_eff_sub_q    <= 1'b0;
            r_special_q    <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_exp_q        <= w_exp_d;
            r_mant_big_q   <= w_mant_big_d;
            r_mant_small_q <= w_mant_small_d;
            r_sign_big_q   <= w_sign_big_d;
            r_eff_sub_q    <= w_eff_sub_d;
            r_special_q    <= w_special_d;
        end
    end

    assign Out_valid  = (r_state_q == DONE);
    assign Exp_out    = r_exp_q;
    assign Mant_big   = r_mant_big_q;
    assign Mant_small = r_mant_small_q;
    assign Sign_big   = r_sign_big_q;
    assign Eff_sub    = r_eff_sub_q;
    assign Special    = r_special_q;

endmodule
`default_nettype wire
